// File: rtl/ft245_pkg.sv
// ft245_pkg
//   Shared definitions for the FT245 FIFO bridge: pin width, default timing
//   constants and the bridge FSM state encoding.
package ft245_pkg;

  localparam int PIN_W           = 8;
  localparam int DEF_DEPTH       = 16;
  localparam int DEF_RD_PULSE    = 4;
  localparam int DEF_WR_PULSE    = 4;
  localparam int DEF_GAP_CYC     = 2;
  localparam int DEF_SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_STROBE,
    ST_WR_SETUP,
    ST_WR_STROBE,
    ST_WR_HOLD,
    ST_GAP
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/ft245_sync_fifo.sv
// ft245_sync_fifo
//   First-word-fall-through synchronous FIFO with occupancy output.
//   DEPTH must be a power of 2 so the pointers wrap naturally.
// Ports
//   clk, rst        clock, asynchronous active-low reset
//   push/push_data  write request; ignored while full (full judged before pop)
//   pop/pop_data    read request; pop_data always shows the head entry
//   full, empty     occupancy flags
//   level           occupancy 0..DEPTH
module ft245_sync_fifo
  import ft245_pkg::*;
#(
  parameter int WIDTH = PIN_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == LW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign pop_data = mem[rd_ptr];
  assign level    = count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/ft245_fifo_bridge.sv
// ft245_fifo_bridge
//   Bridge between FT245-style parallel USB FIFO pins and SoC valid/ready
//   streams. TX and RX bytes are buffered in internal FIFOs; the bridge
//   generates RD/WR/OE pin timing and synchronises TXE#/RXF# itself.
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   uart_di/do/oe/rd/wr      pad-side data and strobes (active high)
//   uart_txe_n, uart_rxf_n   raw asynchronous device flags
//   tx_data/valid/ready      SoC -> TX FIFO stream
//   rx_data/valid/ready      RX FIFO -> SoC stream (first-word fall-through)
//   tx_level, rx_level       FIFO occupancies
//   loopback                 present only when FT245_LOOPBACK_EN is defined
// Optional feature: FT245_LOOPBACK_EN adds the loopback port; while set the
//   FSM idles and TX bytes move straight into RX at one byte per cycle.
//
// state        | meaning
// ST_IDLE      | arbitrate between read and write, or loop back
// ST_RD_STROBE | uart_rd high for RD_PULSE cycles, sample on last
// ST_WR_SETUP  | oe and data driven one cycle before wr
// ST_WR_STROBE | uart_wr high for WR_PULSE cycles
// ST_WR_HOLD   | wr low, oe/data held, TX FIFO pops
// ST_GAP       | strobes low until synced flags reflect the transfer
module ft245_fifo_bridge
  import ft245_pkg::*;
#(
  parameter int TX_DEPTH    = DEF_DEPTH,
  parameter int RX_DEPTH    = DEF_DEPTH,
  parameter int RD_PULSE    = DEF_RD_PULSE,
  parameter int WR_PULSE    = DEF_WR_PULSE,
  parameter int GAP_CYC     = DEF_GAP_CYC,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PIN_W-1:0]            uart_di,
  output logic [PIN_W-1:0]            uart_do,
  output logic                        uart_oe,
  output logic                        uart_rd,
  output logic                        uart_wr,
  input  logic                        uart_txe_n,
  input  logic                        uart_rxf_n,
  input  logic [PIN_W-1:0]            tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic [PIN_W-1:0]            rx_data,
  output logic                        rx_valid,
  input  logic                        rx_ready,
  output logic [$clog2(TX_DEPTH):0]   tx_level,
  output logic [$clog2(RX_DEPTH):0]   rx_level
`ifdef FT245_LOOPBACK_EN
  ,
  input  logic                        loopback
`endif
);

  localparam int CNT_MAX = max3(RD_PULSE - 1, WR_PULSE - 1, GAP_CYC + SYNC_STAGES - 1);
  localparam int CNT_W   = $clog2(CNT_MAX + 2);

  state_t               state, state_n;
  logic [CNT_W-1:0]     cnt, cnt_n;
  logic                 last_rd, last_rd_n;
  logic                 run_q;
  logic [SYNC_STAGES-1:0] txe_sync, rxf_sync;
  logic                 txe_n_s, rxf_n_s;
  logic                 tx_full, tx_empty, rx_full, rx_empty;
  logic [PIN_W-1:0]     tx_head, rx_push_data;
  logic                 tx_pop, rx_push, tx_pop_fsm, rx_push_fsm;
  logic                 rd_ok, wr_ok, lb_hold, lb_move;

`ifdef FT245_LOOPBACK_EN
  assign lb_hold = loopback;
`else
  assign lb_hold = 1'b0;
`endif

  // Flags reset to the inactive level so nothing is granted until the
  // chain has been filled from the pins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txe_sync <= '1;
      rxf_sync <= '1;
      run_q    <= 1'b0;
    end else begin
      txe_sync <= {txe_sync[SYNC_STAGES-2:0], uart_txe_n};
      rxf_sync <= {rxf_sync[SYNC_STAGES-2:0], uart_rxf_n};
      run_q    <= 1'b1;
    end
  end

  assign txe_n_s = txe_sync[SYNC_STAGES-1];
  assign rxf_n_s = rxf_sync[SYNC_STAGES-1];

  assign rd_ok   = ~rxf_n_s & ~rx_full;
  assign wr_ok   = ~txe_n_s & ~tx_empty;
  assign lb_move = lb_hold & (state == ST_IDLE) & ~tx_empty & ~rx_full;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      last_rd <= 1'b0;   // pretend the last grant was a write so RD goes first
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      last_rd <= last_rd_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    last_rd_n   = last_rd;
    tx_pop_fsm  = 1'b0;
    rx_push_fsm = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!lb_hold) begin
          if (rd_ok && (!wr_ok || !last_rd)) begin
            state_n   = ST_RD_STROBE;
            cnt_n     = CNT_W'(RD_PULSE - 1);
            last_rd_n = 1'b1;
          end else if (wr_ok) begin
            state_n   = ST_WR_SETUP;
            last_rd_n = 1'b0;
          end
        end
      end
      ST_RD_STROBE: begin
        if (cnt == '0) begin
          rx_push_fsm = 1'b1;
          state_n     = ST_GAP;
          cnt_n       = CNT_W'(GAP_CYC + SYNC_STAGES - 1);
        end else begin
          cnt_n = cnt - CNT_W'(1);
        end
      end
      ST_WR_SETUP: begin
        state_n = ST_WR_STROBE;
        cnt_n   = CNT_W'(WR_PULSE - 1);
      end
      ST_WR_STROBE: begin
        if (cnt == '0) state_n = ST_WR_HOLD;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      ST_WR_HOLD: begin
        tx_pop_fsm = 1'b1;
        state_n    = ST_GAP;
        cnt_n      = CNT_W'(GAP_CYC + SYNC_STAGES - 1);
      end
      ST_GAP: begin
        if (cnt == '0) state_n = ST_IDLE;
        else           cnt_n   = cnt - CNT_W'(1);
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Pin outputs decode straight from the state register, so an async reset
  // drops every strobe in the same cycle.
  assign uart_rd = (state == ST_RD_STROBE);
  assign uart_wr = (state == ST_WR_STROBE);
  assign uart_oe = (state == ST_WR_SETUP) | (state == ST_WR_STROBE) | (state == ST_WR_HOLD);
  assign uart_do = uart_oe ? tx_head : '0;

  assign tx_pop       = tx_pop_fsm | lb_move;
  assign rx_push      = rx_push_fsm | lb_move;
  assign rx_push_data = lb_move ? tx_head : uart_di;
  assign tx_ready     = ~tx_full & run_q;
  assign rx_valid     = ~rx_empty;

  ft245_sync_fifo #(.WIDTH(PIN_W), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_valid & run_q),
    .push_data (tx_data),
    .pop       (tx_pop),
    .pop_data  (tx_head),
    .full      (tx_full),
    .empty     (tx_empty),
    .level     (tx_level)
  );

  ft245_sync_fifo #(.WIDTH(PIN_W), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_push),
    .push_data (rx_push_data),
    .pop       (rx_ready),
    .pop_data  (rx_data),
    .full      (rx_full),
    .empty     (rx_empty),
    .level     (rx_level)
  );

endmodule

// File: tb/tb_ft245_fifo_bridge.sv
// tb_ft245_fifo_bridge
//   Bench for ft245_fifo_bridge: directed scenarios followed by randomized
//   traffic, checked against a queue-based model of the two FIFOs and a pin
//   protocol monitor that emulates the FT245 device.
module tb_ft245_fifo_bridge;
  import ft245_pkg::*;

  localparam int TXD  = 16;
  localparam int RXD  = 16;
  localparam int RDP  = 4;
  localparam int WRP  = 4;
  localparam int GAPC = 2;
  localparam int SYNC = 2;
  localparam int MIN_IDLE = GAPC + SYNC + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] uart_di, uart_do, tx_data, rx_data;
  logic       uart_oe, uart_rd, uart_wr, uart_txe_n, uart_rxf_n;
  logic       tx_valid, tx_ready, rx_valid, rx_ready;
  logic [4:0] tx_level, rx_level;
`ifdef FT245_LOOPBACK_EN
  logic       loopback;
`endif

  ft245_fifo_bridge #(
    .TX_DEPTH(TXD), .RX_DEPTH(RXD), .RD_PULSE(RDP), .WR_PULSE(WRP),
    .GAP_CYC(GAPC), .SYNC_STAGES(SYNC)
  ) dut (
    .clk(clk), .rst(rst), .uart_di(uart_di), .uart_do(uart_do),
    .uart_oe(uart_oe), .uart_rd(uart_rd), .uart_wr(uart_wr),
    .uart_txe_n(uart_txe_n), .uart_rxf_n(uart_rxf_n),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_level(tx_level), .rx_level(rx_level)
`ifdef FT245_LOOPBACK_EN
    , .loopback(loopback)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // reference model state
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];
  bit         model_run = 0;
  logic [7:0] dev_byte;
  byte        gq[$];

  // pin monitor state
  int   rd_run = 0, oe_run = 0, wr_cnt = 0, pre_cnt = 0, post_cnt = 0;
  int   idle_run = 100;
  bit   rx_push_evt = 0, tx_pop_evt = 0;
  logic [7:0] rxf_hist = '1, txe_hist = '1;

  function automatic logic [7:0] tx_head();
    return (tx_q.size() > 0) ? tx_q[0] : 8'h00;
  endfunction

  task automatic monitor();
    rxf_hist    = {rxf_hist[6:0], uart_rxf_n};
    txe_hist    = {txe_hist[6:0], uart_txe_n};
    rx_push_evt = 0;
    tx_pop_evt  = 0;
    chk("inv_oe_rd", {31'd0, uart_oe & uart_rd}, 0);
    chk("inv_rd_wr", {31'd0, uart_rd & uart_wr}, 0);
    chk("tx_level", tx_level, tx_q.size());
    chk("rx_level", rx_level, rx_q.size());
    chk("tx_ready", tx_ready, model_run && (tx_q.size() < TXD));
    chk("rx_valid", rx_valid, rx_q.size() > 0);
    if (rx_q.size() > 0) chk("rx_data", rx_data, rx_q[0]);
    if (!rst) begin
      chk("rst_pins", {uart_oe, uart_rd, uart_wr}, 0);
      chk("rst_do", uart_do, 0);
      rd_run = 0; oe_run = 0; wr_cnt = 0; pre_cnt = 0; post_cnt = 0;
      idle_run = 100;
      return;
    end
    if (uart_rd) begin
      if (rd_run == 0) begin
        gq.push_back("R");
        chk("rd_gap", idle_run >= MIN_IDLE, 1);
        chk("rd_rxf", rxf_hist[SYNC], 0);
      end
      rd_run++;
      if (rd_run == RDP) rx_push_evt = 1;
    end else if (rd_run != 0) begin
      chk("rd_len", rd_run, RDP);
      rd_run   = 0;
      idle_run = 0;
    end
    if (uart_wr) chk("wr_oe", uart_oe, 1);
    if (uart_oe) begin
      if (oe_run == 0) begin
        gq.push_back("W");
        chk("wr_gap", idle_run >= MIN_IDLE, 1);
        chk("wr_txe", txe_hist[SYNC], 0);
      end
      oe_run++;
      chk("do_data", uart_do, tx_head());
      if (uart_wr) wr_cnt++;
      else if (wr_cnt == 0) pre_cnt++;
      else begin
        post_cnt++;
        if (post_cnt == 1) tx_pop_evt = 1;
      end
    end else if (oe_run != 0) begin
      chk("oe_pre", pre_cnt, 1);
      chk("wr_len", wr_cnt, WRP);
      chk("oe_post", post_cnt, 1);
      oe_run = 0; wr_cnt = 0; pre_cnt = 0; post_cnt = 0;
      idle_run = 0;
    end
    if (!uart_rd && !uart_oe) idle_run++;
  endtask

  // Applies the FIFO rules for the coming clock edge, then advances to the
  // next falling edge and checks the DUT against the model.
  task automatic cycle();
    bit         tx_acc, rx_pop, rx_push, lb_evt, rx_was_full;
    logic [7:0] pb;
    lb_evt = 0;
`ifdef FT245_LOOPBACK_EN
    lb_evt = loopback && rst && (idle_run >= MIN_IDLE) && (rd_run == 0) && (oe_run == 0) &&
             (tx_q.size() > 0) && (rx_q.size() < RXD);
`endif
    if (!rst) begin
      tx_q.delete();
      rx_q.delete();
      model_run = 0;
    end else begin
      tx_acc      = tx_valid && model_run && (tx_q.size() < TXD);
      rx_pop      = rx_ready && (rx_q.size() > 0);
      rx_push     = rx_push_evt || lb_evt;
      rx_was_full = rx_q.size() >= RXD;
      pb          = lb_evt ? tx_head() : dev_byte;
      if ((tx_pop_evt || lb_evt) && tx_q.size() > 0) void'(tx_q.pop_front());
      if (tx_acc) tx_q.push_back(tx_data);
      if (rx_pop) void'(rx_q.pop_front());
      if (rx_push && !rx_was_full) rx_q.push_back(pb);
      model_run = 1;
    end
    @(posedge clk);
    @(negedge clk);
    if (rx_push_evt) begin
      dev_byte = 8'($urandom);
      uart_di  = dev_byte;
    end
    monitor();
  endtask

  task automatic push_byte(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    cycle();
    tx_valid = 1'b0;
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int    nr;
    int    ftimer;
    string exp_g;
    rst = 1'b0; tx_valid = 1'b0; tx_data = 8'h00; rx_ready = 1'b0;
    uart_txe_n = 1'b1; uart_rxf_n = 1'b0;
    dev_byte = 8'hA5; uart_di = dev_byte;
`ifdef FT245_LOOPBACK_EN
    loopback = 1'b0;
`endif

    // reset held with RXF# low: nothing moves
    repeat (4) cycle();
    chk("rst_rd", uart_rd, 0);
    chk("rst_tx_ready", tx_ready, 0);
    chk("rst_rx_level", rx_level, 0);
    rst = 1'b1;
    cycle();
    chk("rel_tx_ready", tx_ready, 1);

    // RX: first byte read from pins is A5
    for (int i = 0; i < 40 && !rx_valid; i++) cycle();
    chk("rx_first_valid", rx_valid, 1);
    chk("rx_first_data", rx_data, 8'hA5);
    repeat (20) cycle();

    // TX single byte
    uart_rxf_n = 1'b1; rx_ready = 1'b1;
    repeat (20) cycle();
    uart_txe_n = 1'b0;
    push_byte(8'h3C);
    for (int i = 0; i < 40 && !uart_oe; i++) cycle();
    chk("tx_oe_seen", uart_oe, 1);
    chk("tx_do", uart_do, 8'h3C);
    repeat (15) cycle();
    chk("tx_drained", tx_level, 0);

    // full TX FIFO
    uart_txe_n = 1'b1;
    repeat (10) cycle();
    for (int i = 0; i < 17; i++) push_byte(8'(8'h40 + i));
    chk("full_level", tx_level, 16);
    chk("full_ready", tx_ready, 0);
    push_byte(8'hEE);
    chk("full_push_level", tx_level, 16);
    uart_txe_n = 1'b0;
    for (int i = 0; i < 400 && tx_level != 0; i++) cycle();
    chk("full_drain", tx_level, 0);

    // contention: grants alternate, first grant after reset is RD
    uart_txe_n = 1'b1; uart_rxf_n = 1'b1;
    rst = 1'b0; repeat (2) cycle(); rst = 1'b1; cycle();
    for (int i = 0; i < 3; i++) push_byte(8'(8'h90 + i));
    repeat (4) cycle();
    gq.delete();
    rx_ready = 1'b1; uart_txe_n = 1'b0; uart_rxf_n = 1'b0;
    for (int i = 0; i < 300 && gq.size() < 7; i++) cycle();
    chk("grant_count", gq.size(), 7);
    exp_g = "RWRWRWR";
    for (int k = 0; k < 7; k++)
      chk($sformatf("grant%0d", k), (k < gq.size()) ? 32'(gq[k]) : 32'd0, 32'(exp_g[k]));
    rx_ready = 1'b0;
    for (int i = 0; i < 600 && rx_level != 16; i++) cycle();
    chk("rx_full_level", rx_level, 16);
    nr = gq.size();
    repeat (60) cycle();
    chk("rd_withheld", gq.size(), nr);
    rx_ready = 1'b1;
    repeat (20) cycle();

    // reset during WR_STROBE
    uart_rxf_n = 1'b1; uart_txe_n = 1'b0;
    repeat (10) cycle();
    for (int i = 0; i < 4; i++) push_byte(8'(8'hC0 + i));
    for (int i = 0; i < 100 && !uart_wr; i++) cycle();
    chk("mid_wr_seen", uart_wr, 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_wr", uart_wr, 0);
    chk("mid_rst_oe", uart_oe, 0);
    chk("mid_rst_tx_level", tx_level, 0);
    chk("mid_rst_rx_valid", rx_valid, 0);
    cycle(); cycle();
    rst = 1'b1;
    cycle();

    // randomized traffic
    ftimer = 0;
    for (int c = 0; c < 3000; c++) begin
      tx_valid = 1'($urandom_range(0, 1));
      tx_data  = 8'($urandom);
      rx_ready = (c < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
      if (ftimer == 0 && !uart_rd && !uart_oe) begin
        uart_rxf_n = 1'($urandom_range(0, 1));
        uart_txe_n = 1'($urandom_range(0, 1));
        ftimer     = $urandom_range(0, 20);
      end else if (ftimer > 0) begin
        ftimer--;
      end
      cycle();
    end
    tx_valid = 1'b0;

`ifdef FT245_LOOPBACK_EN
    // loopback: TX bytes appear on RX in order, pins stay idle
    uart_txe_n = 1'b1; uart_rxf_n = 1'b1; rx_ready = 1'b0;
    rst = 1'b0; repeat (2) cycle();
    loopback = 1'b1; rst = 1'b1;
    repeat (8) cycle();
    for (int i = 1; i <= 4; i++) begin
      push_byte(8'(i));
      repeat (3) cycle();
      chk("lb_pins", {uart_oe, uart_rd, uart_wr}, 0);
    end
    for (int k = 0; k < 4; k++) begin
      chk("lb_data", rx_data, k + 1);
      rx_ready = 1'b1;
      cycle();
      rx_ready = 1'b0;
    end
    loopback = 1'b0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
